// File: rtl/vscale_hpm_counters_pkg.sv
// Shared CSR address map, command encodings and helpers for the vscale
// hardware performance monitor counters.
package vscale_hpm_counters_pkg;

    localparam int XPR_LEN        = 32;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH  = 3;

    localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MHPMEVENT3    = 12'h323;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
    // Overflow status/enable live in the custom machine read/write range.
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MHPMOVF       = 12'h7C0;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MHPMOVFEN     = 12'h7C1;

    localparam int SEL_WIDTH = 5;

    typedef enum logic [1:0] {
        FIXED_NONE,
        FIXED_INHIBIT,
        FIXED_OVF,
        FIXED_OVFEN
    } fixed_csr_e;

    function automatic fixed_csr_e decode_fixed(input logic [CSR_ADDR_WIDTH-1:0] addr);
        case (addr)
            CSR_ADDR_MCOUNTINHIBIT: return FIXED_INHIBIT;
            CSR_ADDR_MHPMOVF:       return FIXED_OVF;
            CSR_ADDR_MHPMOVFEN:     return FIXED_OVFEN;
            default:                return FIXED_NONE;
        endcase
    endfunction

    function automatic logic [XPR_LEN-1:0] csr_wr_value(
        input logic [CSR_CMD_WIDTH-1:0] cmd,
        input logic [XPR_LEN-1:0]       rdata,
        input logic [XPR_LEN-1:0]       wdata
    );
        case (cmd)
            CSR_SET:   return rdata | wdata;
            CSR_CLEAR: return rdata & ~wdata;
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/vscale_hpm_counter.sv
// One performance counter: event select register, increment, wrap and
// per-half software write.
module vscale_hpm_counter
    import vscale_hpm_counters_pkg::*;
#(
    parameter int N_EVENTS  = 8,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_EVENTS-1:0]  events,
    input  logic                 inhibit,
    input  logic                 sel_we,
    input  logic                 lo_we,
    input  logic                 hi_we,
    input  logic [XPR_LEN-1:0]   wdata,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf_set
);

    localparam int HI_WIDTH = CNT_WIDTH - XPR_LEN;

    logic             hit;
    logic             inc;
    logic [CNT_WIDTH:0] sum;

    // Select value e+1 picks events[e]; 0 and out-of-range values match nothing.
    always_comb begin
        hit = 1'b0;
        for (int e = 0; e < N_EVENTS; e++) begin
            if (sel == SEL_WIDTH'(e + 1)) begin
                hit = events[e];
            end
        end
    end

    assign inc     = hit & ~inhibit;
    assign sum     = {1'b0, count} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign ovf_set = inc & sum[CNT_WIDTH] & ~(lo_we | hi_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel   <= '0;
            count <= '0;
        end else begin
            if (sel_we) begin
                sel <= wdata[SEL_WIDTH-1:0];
            end
            // A half write replaces this cycle's increment; the other half holds.
            if (lo_we) begin
                count[XPR_LEN-1:0] <= wdata;
            end else if (hi_we) begin
                count[CNT_WIDTH-1:XPR_LEN] <= wdata[HI_WIDTH-1:0];
            end else if (inc) begin
                count <= sum[CNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/vscale_hpm_counters.sv
// HPM counter bank: CSR decode, read mux, inhibit/overflow registers and the
// overflow interrupt around N_COUNTERS vscale_hpm_counter instances.
module vscale_hpm_counters
    import vscale_hpm_counters_pkg::*;
#(
    parameter int N_COUNTERS = 4,
    parameter int N_EVENTS   = 8,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CSR_ADDR_WIDTH-1:0] addr,
    input  logic [CSR_CMD_WIDTH-1:0]  cmd,
    input  logic [XPR_LEN-1:0]        wdata,
    output logic [XPR_LEN-1:0]        rdata,
    output logic                      defined,
    input  logic [N_EVENTS-1:0]       events,
    output logic                      ovf_irq
);

    logic [CNT_WIDTH-1:0]  counts [N_COUNTERS];
    logic [SEL_WIDTH-1:0]  sels   [N_COUNTERS];
    logic [N_COUNTERS-1:0] lo_hit, hi_hit, ev_hit;
    logic [N_COUNTERS-1:0] ovf_set;
    logic [N_COUNTERS-1:0] inhibit, ovf, ovfen, ovf_next;
    fixed_csr_e            fixed_sel;
    logic                  wr_en;
    logic [XPR_LEN-1:0]    wr_data;

    assign fixed_sel = decode_fixed(addr);

    always_comb begin
        lo_hit  = '0;
        hi_hit  = '0;
        ev_hit  = '0;
        rdata   = '0;
        defined = 1'b0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (addr == CSR_ADDR_MHPMCOUNTER3 + CSR_ADDR_WIDTH'(i)) begin
                lo_hit[i] = 1'b1;
                defined   = 1'b1;
                rdata     = counts[i][XPR_LEN-1:0];
            end
            if (addr == CSR_ADDR_MHPMCOUNTER3H + CSR_ADDR_WIDTH'(i)) begin
                hi_hit[i] = 1'b1;
                defined   = 1'b1;
                rdata     = XPR_LEN'(counts[i][CNT_WIDTH-1:XPR_LEN]);
            end
            if (addr == CSR_ADDR_MHPMEVENT3 + CSR_ADDR_WIDTH'(i)) begin
                ev_hit[i] = 1'b1;
                defined   = 1'b1;
                rdata     = XPR_LEN'(sels[i]);
            end
        end
        case (fixed_sel)
            FIXED_INHIBIT: begin
                defined = 1'b1;
                rdata   = XPR_LEN'({inhibit, 3'b000});
            end
            FIXED_OVF: begin
                defined = 1'b1;
                rdata   = XPR_LEN'(ovf);
            end
            FIXED_OVFEN: begin
                defined = 1'b1;
                rdata   = XPR_LEN'(ovfen);
            end
            default: ;
        endcase
    end

    assign wr_en   = cmd[2] & (cmd[1] | cmd[0]) & defined;
    assign wr_data = csr_wr_value(cmd, rdata, wdata);

    for (genvar g = 0; g < N_COUNTERS; g++) begin : g_cnt
        vscale_hpm_counter #(
            .N_EVENTS  (N_EVENTS),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_counter (
            .clk     (clk),
            .reset   (reset),
            .events  (events),
            .inhibit (inhibit[g]),
            .sel_we  (wr_en & ev_hit[g]),
            .lo_we   (wr_en & lo_hit[g]),
            .hi_we   (wr_en & hi_hit[g]),
            .wdata   (wr_data),
            .sel     (sels[g]),
            .count   (counts[g]),
            .ovf_set (ovf_set[g])
        );
    end

    // Hardware overflow wins over a software clear landing on the same edge.
    always_comb begin
        ovf_next = ovf;
        if (wr_en && fixed_sel == FIXED_OVF) begin
            ovf_next = wr_data[N_COUNTERS-1:0];
        end
        ovf_next = ovf_next | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit <= '0;
            ovf     <= '0;
            ovfen   <= '0;
            ovf_irq <= 1'b0;
        end else begin
            if (wr_en && fixed_sel == FIXED_INHIBIT) begin
                inhibit <= wr_data[N_COUNTERS+2:3];
            end
            if (wr_en && fixed_sel == FIXED_OVFEN) begin
                ovfen <= wr_data[N_COUNTERS-1:0];
            end
            ovf     <= ovf_next;
            ovf_irq <= |(ovf & ovfen);
        end
    end

endmodule

// File: doc/vscale_hpm_counters.md
VSCALE_HPM_COUNTERS -- requirements
Module: vscale_hpm_counters

Interface
REQ-001 The parameter list SHALL be exactly: N_COUNTERS, default 4, number of counters (1..29); N_EVENTS, default 8, event input count (1..31); CNT_WIDTH, default 64, counter width (XPR_LEN+1..2*XPR_LEN).
REQ-002 The port list SHALL start with clk, input, 1 bit, the clock.
REQ-003 The next port SHALL be reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port addr, input, CSR_ADDR_WIDTH, the CSR address.
REQ-005 The block SHALL have port cmd, input, CSR_CMD_WIDTH, the CSR command; cmd[2] is access enable, and cmd[1] or cmd[0] marks a write.
REQ-006 The block SHALL have port wdata, input, XPR_LEN, the CSR write operand.
REQ-007 The block SHALL have port rdata, output, XPR_LEN, combinational read data for addr.
REQ-008 The block SHALL have port defined, output, 1 bit, high when addr maps to this block.
REQ-009 The block SHALL have port events, input, N_EVENTS, per-cycle event strobes.
REQ-010 The block SHALL have port ovf_irq, output, 1 bit, the overflow interrupt request.

Function
REQ-011 Counter i SHALL map: low half at CSR_ADDR_MHPMCOUNTER3+i; high half at CSR_ADDR_MHPMCOUNTER3H+i; event select at CSR_ADDR_MHPMEVENT3+i.
REQ-012 The block SHALL also map CSR_ADDR_MCOUNTINHIBIT (bit 3+i inhibits counter i), CSR_ADDR_MHPMOVF (bit i is the sticky overflow of counter i) and CSR_ADDR_MHPMOVFEN (bit i is the overflow interrupt enable).
REQ-013 For any other addr, defined SHALL be 0 and rdata SHALL be 0.
REQ-014 Unimplemented bits SHALL read 0 and ignore writes; the high half SHALL read zero-extended when CNT_WIDTH < 2*XPR_LEN.
REQ-015 Write data SHALL be: wdata for CSR_WRITE, rdata|wdata for CSR_SET, rdata&~wdata for CSR_CLEAR.
REQ-016 A write SHALL occur only when cmd[2] and (cmd[1] or cmd[0]) and defined, and SHALL take effect at the next clk edge.
REQ-017 Counter i SHALL increment by 1 per cycle when its inhibit bit is 0, sel_i is in 1..N_EVENTS, and events[sel_i-1] is 1.
REQ-018 Select value 0 or any value above N_EVENTS SHALL count nothing.
REQ-019 When an increment carries out of CNT_WIDTH-1, the counter SHALL wrap to 0 and set ovf[i] on the same edge.
REQ-020 A write to either half of counter i SHALL override that cycle's increment: the written half takes the write data, the other half holds its current value, and ovf[i] is unaffected.
REQ-021 When an overflow and a software write of ovf[i] to 0 occur on the same edge, the overflow set SHALL win.
REQ-022 ovf_irq SHALL be the registered OR of (ovf & ovfen), with 1-cycle latency after ovf or ovfen changes.
REQ-023 Counters SHALL operate independently; simultaneous increments on all counters SHALL be supported every cycle.

Reset
REQ-024 Reset SHALL clear all counters, event selects, mcountinhibit, ovf, ovfen and ovf_irq to 0.
REQ-025 Reset SHALL take priority over any concurrent write or increment.
REQ-026 Reset asserted mid-count SHALL leave all counters at 0 on the first edge after reset deasserts, with counting resuming from that cycle.

Structure
REQ-027 The new CSR addresses (MHPMCOUNTER3/3H, MHPMEVENT3, MCOUNTINHIBIT, MHPMOVF, MHPMOVFEN) SHALL be added to the shared CSR address map header.
REQ-028 Command encodings SHALL come from the shared control constants header; no local redefinition is permitted.
REQ-029 The design SHALL contain one sub-module, vscale_hpm_counter, instantiated N_COUNTERS times by generate. It holds one counter with its select, increment, wrap and half-write logic.
REQ-030 Address decode, read mux, ovf/ovfen and the irq register SHALL reside in the top module.

Verification
REQ-031 Reset: sel0=1, events[0]=1 for 10 cycles -> counter0 reads 10; the other counters read 0.
REQ-032 Wrap: CNT_WIDTH=64; write low=FFFFFFFF, high=FFFFFFFF; ovfen=1; one event -> counter reads 0, ovf[0]=1, ovf_irq=1 one cycle later.
REQ-033 Write priority: counter1 counting every cycle; CSR_WRITE low=0x100 -> next cycle reads 0x100, high half unchanged, then 0x101.
REQ-034 Inhibit and select: mcountinhibit bit 4=1 -> counter1 frozen; sel=0 or sel=N_EVENTS+1 -> no count with all events high.
REQ-035 Set/clear race: CSR_CLEAR ovf bit 2 on the same edge as counter2 overflows -> ovf[2] stays 1.
REQ-036 Decode: read an undefined address -> defined=0, rdata=0; CSR_SET on mhpmevent3 with 0x2 after writing 0x1 -> reads 0x3.
